// File: rtl/prio_code_fifo_if.sv
// prio_code_fifo_if
// Groups the encoder-side sample inputs and the consumer-side handshake of
// prio_code_fifo into one bundle.
//   Y, valid       : registered encoder code and its qualifier
//   out_code       : code at the FIFO head (0 while out_valid = 0)
//   out_valid      : head entry present
//   out_ready      : consumer accepts the head this cycle
//   count          : entries held, 0..DEPTH
//   full, empty    : decoded from count
//   overflow       : sticky, set when an event is dropped
//   ovf_cnt        : saturating dropped-event count (PRIO_FIFO_OVF_CNT_EN only)
// Handshake: a head entry transfers on every rising edge where
// out_valid && out_ready. out_valid depends on stored state only and never on
// out_ready, and out_ready is ignored while out_valid = 0.
// Modports: master = encoder + consumer side (testbench), slave = the FIFO.
interface prio_code_fifo_if #(
  parameter int DEPTH = 4,
  parameter int W     = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [W-1:0]  Y;
  logic          valid;
  logic [W-1:0]  out_code;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow;
`ifdef PRIO_FIFO_OVF_CNT_EN
  logic [7:0]    ovf_cnt;
`endif

  modport master (
    output Y, valid, out_ready,
    input  out_code, out_valid, count, full, empty, overflow
`ifdef PRIO_FIFO_OVF_CNT_EN
    , input ovf_cnt
`endif
  );

  modport slave (
    input  Y, valid, out_ready,
    output out_code, out_valid, count, full, empty, overflow
`ifdef PRIO_FIFO_OVF_CNT_EN
    , output ovf_cnt
`endif
  );
endinterface

// File: rtl/prio_code_fifo.sv
// prio_code_fifo
// Samples the priority encoder's registered code/valid every cycle, turns new
// requests (rising valid or a code change while valid) into single events, and
// queues each event's code in a DEPTH-entry FIFO drained over valid/ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset; discards all queued entries
//   bus  : prio_code_fifo_if.slave (see interface file for signal list)
// Optional feature: define PRIO_FIFO_OVF_CNT_EN to add the 8-bit saturating
// ovf_cnt output. Without it the port and its logic are absent.
module prio_code_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic           clk,
  input  logic           rst,
  prio_code_fifo_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic          prev_valid_q, prev_valid_d;
  logic [W-1:0]  prev_code_q,  prev_code_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;

  logic ev, push, pop, drop, full, empty;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A held request is one event; a code change while valid stays high is a new one.
  assign ev   = bus.valid && (!prev_valid_q || (bus.Y != prev_code_q));
  assign pop  = !empty && bus.out_ready;
  // When full, a same-cycle pop frees the slot the push writes into.
  assign push = ev && (!full || pop);
  assign drop = ev && full && !pop;

  always_comb begin
    prev_valid_d = bus.valid;
    prev_code_d  = bus.Y;
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    overflow_d   = overflow_q | drop;

    if (push) begin
      mem_d[wr_ptr_q] = bus.Y;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_valid_q <= 1'b0;
      prev_code_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_valid_q <= prev_valid_d;
      prev_code_q  <= prev_code_d;
      mem_q        <= mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.out_valid = !empty;
  assign bus.out_code  = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count     = count_q;
  assign bus.full      = full;
  assign bus.empty     = empty;
  assign bus.overflow  = overflow_q;

`ifdef PRIO_FIFO_OVF_CNT_EN
  logic [7:0] ovf_cnt_q, ovf_cnt_d;

  // Saturates at 255 so a long overflow burst never wraps back to a small count.
  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (drop && (ovf_cnt_q != 8'hFF)) ovf_cnt_d = ovf_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_cnt_q <= 8'd0;
    else     ovf_cnt_q <= ovf_cnt_d;
  end

  assign bus.ovf_cnt = ovf_cnt_q;
`endif
endmodule

// File: tb/tb_prio_code_fifo.sv
module tb_prio_code_fifo;
  localparam int DEPTH = 4;
  localparam int W     = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  prio_code_fifo_if #(.DEPTH(DEPTH), .W(W)) bus ();

  prio_code_fifo #(.DEPTH(DEPTH), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // ---------------- reference model ----------------
  // Queue of pending codes plus the last sampled encoder pair.
  logic [W-1:0] exp_q[$];
  logic         m_prev_v   = 1'b0;
  logic [W-1:0] m_prev_c   = '0;
  logic         m_ovf      = 1'b0;
  int           m_ovf_cnt  = 0;

  task automatic model_edge();
    bit ev, was_full, do_pop;
    if (rst) begin
      exp_q.delete();
      m_prev_v  = 1'b0;
      m_prev_c  = '0;
      m_ovf     = 1'b0;
      m_ovf_cnt = 0;
    end else begin
      ev       = bus.valid && (!m_prev_v || bus.Y != m_prev_c);
      was_full = (exp_q.size() == DEPTH);
      do_pop   = (exp_q.size() > 0) && bus.out_ready;
      if (do_pop) void'(exp_q.pop_front());
      if (ev) begin
        if (!was_full || do_pop) exp_q.push_back(bus.Y);
        else begin
          m_ovf = 1'b1;
          if (m_ovf_cnt < 255) m_ovf_cnt++;
        end
      end
      m_prev_v = bus.valid;
      m_prev_c = bus.Y;
    end
  endtask

  // ---------------- driver ----------------
  // Advances one clock with the currently driven inputs; outputs are then
  // stable for sampling 1 time unit after the edge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] y, input logic rdy);
    bus.valid     = v;
    bus.Y         = y;
    bus.out_ready = rdy;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    drive(1'b1, 2'd2, 1'b0);
    tick();
    tick();
    checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0) begin failures++; $display("FAIL reset_flags empty=%0b full=%0b exp empty=1 full=0", bus.empty, bus.full); end
    checks++; if (bus.overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", bus.overflow); end
    checks++; if (bus.out_code !== 2'd0) begin failures++; $display("FAIL reset_out_code got=%0d exp=0", bus.out_code); end
`ifdef PRIO_FIFO_OVF_CNT_EN
    checks++; if (bus.ovf_cnt !== 8'd0) begin failures++; $display("FAIL reset_ovf_cnt got=%0d exp=0", bus.ovf_cnt); end
`endif
    rst = 1'b0;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== 2'd2 || bus.count !== 3'd1)
      begin failures++; $display("FAIL reset_release_event valid=%0b code=%0d count=%0d exp 1/2/1", bus.out_valid, bus.out_code, bus.count); end
  endtask

  task automatic test_hold();
    do_reset();
    drive(1'b1, 2'd1, 1'b0);
    repeat (5) tick();
    checks++; if (bus.count !== 3'd1 || bus.out_code !== 2'd1)
      begin failures++; $display("FAIL hold count=%0d code=%0d exp 1/1", bus.count, bus.out_code); end
  endtask

  task automatic test_prio_change();
    logic [W-1:0] seq [5];
    logic [W-1:0] exp_order [4];
    seq = '{2'd3, 2'd3, 2'd1, 2'd1, 2'd0};
    exp_order = '{2'd3, 2'd1, 2'd0, 2'd0};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, seq[i], 1'b0);
      tick();
    end
    checks++; if (bus.count !== 3'd3) begin failures++; $display("FAIL prio_count got=%0d exp=3", bus.count); end
    drive(1'b0, 2'd0, 1'b0);
    tick();
    drive(1'b1, 2'd0, 1'b0);
    tick();
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1) begin failures++; $display("FAIL prio_refire count=%0d full=%0b exp 4/1", bus.count, bus.full); end
    drive(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_valid !== 1'b1 || bus.out_code !== exp_order[i])
        begin failures++; $display("FAIL prio_pop%0d valid=%0b code=%0d exp=%0d", i, bus.out_valid, bus.out_code, exp_order[i]); end
      tick();
    end
    checks++; if (bus.empty !== 1'b1 || bus.out_valid !== 1'b0) begin failures++; $display("FAIL prio_drained empty=%0b valid=%0b", bus.empty, bus.out_valid); end
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp_order [4];
    exp_order = '{2'd0, 2'd1, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, W'(i % 2), 1'b0);
      tick();
    end
    checks++; if (bus.count !== 3'd4 || bus.full !== 1'b1 || bus.overflow !== 1'b1)
      begin failures++; $display("FAIL ovf_state count=%0d full=%0b ovf=%0b exp 4/1/1", bus.count, bus.full, bus.overflow); end
`ifdef PRIO_FIFO_OVF_CNT_EN
    checks++; if (bus.ovf_cnt !== 8'd2) begin failures++; $display("FAIL ovf_cnt got=%0d exp=2", bus.ovf_cnt); end
`endif
    drive(1'b0, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_code !== exp_order[i])
        begin failures++; $display("FAIL ovf_pop%0d got=%0d exp=%0d", i, bus.out_code, exp_order[i]); end
      tick();
    end
    checks++; if (bus.overflow !== 1'b1 || bus.empty !== 1'b1)
      begin failures++; $display("FAIL ovf_sticky ovf=%0b empty=%0b exp 1/1", bus.overflow, bus.empty); end
  endtask

  task automatic test_full_push_pop();
    logic [W-1:0] exp_order [4];
    exp_order = '{2'd1, 2'd2, 2'd3, 2'd0};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, W'(i), 1'b0);
      tick();
    end
    checks++; if (bus.full !== 1'b1) begin failures++; $display("FAIL fpp_fill full=%0b exp=1", bus.full); end
    drive(1'b1, 2'd0, 1'b1);
    tick();
    checks++; if (bus.count !== 3'd4 || bus.overflow !== 1'b0 || bus.out_code !== 2'd1)
      begin failures++; $display("FAIL fpp_both count=%0d ovf=%0b code=%0d exp 4/0/1", bus.count, bus.overflow, bus.out_code); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus.out_code !== exp_order[i])
        begin failures++; $display("FAIL fpp_pop%0d got=%0d exp=%0d", i, bus.out_code, exp_order[i]); end
      tick();
    end
  endtask

  task automatic test_empty_push_pop();
    logic [W-1:0] y;
    do_reset();
    drive(1'b1, 2'd2, 1'b1);
    tick();
    checks++; if (bus.count !== 3'd1 || bus.out_code !== 2'd2)
      begin failures++; $display("FAIL epp_first count=%0d code=%0d exp 1/2", bus.count, bus.out_code); end
    for (int k = 0; k < 8; k++) begin
      y = (k % 2 == 0) ? 2'd1 : 2'd2;
      drive(1'b1, y, 1'b1);
      tick();
      checks++; if (bus.count !== 3'd1 || bus.out_code !== y)
        begin failures++; $display("FAIL epp_wrap%0d count=%0d code=%0d exp 1/%0d", k, bus.count, bus.out_code, y); end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] exp_code;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 7, W'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      tick();
      exp_code = (exp_q.size() > 0) ? exp_q[0] : '0;
      checks++;
      if (bus.out_valid !== (exp_q.size() > 0) || bus.out_code !== exp_code ||
          bus.count !== 3'(exp_q.size()) || bus.full !== (exp_q.size() == DEPTH) ||
          bus.empty !== (exp_q.size() == 0) || bus.overflow !== m_ovf) begin
        failures++;
        $display("FAIL rand_cycle%0d valid=%0b code=%0d count=%0d full=%0b empty=%0b ovf=%0b exp count=%0d code=%0d ovf=%0b",
                 n, bus.out_valid, bus.out_code, bus.count, bus.full, bus.empty, bus.overflow,
                 exp_q.size(), exp_code, m_ovf);
      end
`ifdef PRIO_FIFO_OVF_CNT_EN
      checks++; if (bus.ovf_cnt !== 8'(m_ovf_cnt))
        begin failures++; $display("FAIL rand_ovf_cnt%0d got=%0d exp=%0d", n, bus.ovf_cnt, m_ovf_cnt); end
`endif
    end
    rst = 1'b0;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive(1'b0, '0, 1'b0);
    test_reset();
    test_hold();
    test_prio_change();
    test_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/prio_code_fifo.md
# prio_code_fifo

Downstream consumer of the 4-input priority encoder. Samples the encoder's registered code/valid pair every cycle, detects new request events, and queues each event's 2-bit code in a 4-entry FIFO. Codes drain to the service logic over a valid/ready handshake, so a held request produces one queue entry instead of one per cycle.

## Interface
- DEPTH, 4: FIFO entries; a power of two, at least 2.
- W, 2: code width; matches encoder output `Y`.
- clk  in  1  single clock; everything updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Y  in  W  encoder code: 0 = D[3] (highest priority), 3 = D[0].
- valid  in  1  encoder valid; qualifies `Y`.
- out_code  out  W  code at the FIFO head.
- out_valid  out  1  head entry present.
- out_ready  in  1  consumer accepts the head this cycle.
- count  out  log2(DEPTH)+1  entries held, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky flag: an event was dropped.
- ovf_cnt  out  8  dropped-event count; present only with the macro in Configuration.

## Operation
- Edge detector: registers `prev_valid` and `prev_code`, reset to 0 and 0, always loaded with `valid` and `Y`.
- Event: `valid` == 1 and (`prev_valid` == 0 or `Y` != `prev_code`). A held request makes one event. A priority change while `valid` stays high makes a new event.
- `valid` == 0 never makes an event, whatever `Y` holds.
- push = event and (not full, or pop). pop = out_valid and out_ready.
- Storage: DEPTH x W register array. Write pointer and read pointer each log2(DEPTH) bits and wrap modulo DEPTH. `count` is an explicit counter.
- Full, no pop: the event is dropped and `overflow` is set. `overflow` stays 1 until `rst`.
- Full with pop in the same cycle: both happen, and `count` stays DEPTH.
- Empty: out_valid = 0 and out_ready is ignored. A push in the same cycle is accepted normally.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- `out_code` = mem[rd_ptr], a combinational read of registered storage. It is don't-care while out_valid = 0 and is driven to 0 in that state.

## Timing
- Values on reset: out_valid=0, out_code=0, count=0, empty=1, full=0, overflow=0, ovf_cnt=0. Both pointers are 0 and the edge-detector registers are cleared.
- An event sampled at edge N is readable as out_valid=1 immediately after edge N, so the latency is 1 cycle.
- The encoder adds its own 1 register, so D to out_valid is 2 edges.
- Throughput is one push and one pop per cycle.
- Reset mid-operation: all queued entries are discarded. `Y`/`valid` held across reset make a fresh event on the first cycle after `rst` drops, because `prev_valid` is 0.
- `full`, `empty` and `overflow` are registered or decoded from registered `count`; there are no combinational paths from inputs.
- out_ready to out_valid has no combinational dependency. out_valid depends only on state.

## Configuration
- PRIO_FIFO_OVF_CNT_EN defined: adds `ovf_cnt`, an 8-bit counter that increments on each dropped event and saturates at 255. It clears only on `rst`.
- PRIO_FIFO_OVF_CNT_EN undefined: the `ovf_cnt` port and its logic are absent. The sticky `overflow` flag is unaffected.

## Test plan
- Reset: assert `rst` for 2 cycles with valid=1, Y=2 -> out_valid=0, count=0, empty=1, overflow=0. Release `rst` -> one entry with code 2 after the next edge.
- Hold request: valid=1, Y=1 for 5 cycles, out_ready=0 -> count=1, out_code=1. No further pushes.
- Priority change: Y sequence 3,3,1,1,0 with valid=1 -> count=3 and pop order 3,1,0. Then valid=0 for 1 cycle and Y=0 again -> a 4th entry, code 0.
- Overflow: 6 distinct events (alternating 0/1) with out_ready=0 -> count=4, full=1, overflow=1, ovf_cnt=2 when the macro is defined. Pop order is 0,1,0,1.
- Full with simultaneous push and pop: at count=4, an event with out_ready=1 -> count stays 4, overflow stays 0, head advances, new code lands at the tail.
- Empty with simultaneous push and pop: count=0, out_ready=1, event Y=2 -> count=1 and out_code=2 on the next cycle. No underflow, and the pointers stay consistent over 8 wrap-around cycles.
